// File: rtl/cpu_stack_if.sv
// Stack port bundle between the instruction decoder and the hardware stack.
// The decoder side is the master; the stack itself is the slave.
interface cpu_stack_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic             stack_en;
    logic             stack_rw;
    logic             stack_rst;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [SPW-1:0]   sp;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    modport master (
        output stack_en, stack_rw, stack_rst, din,
        input  dout, sp, full, empty, ovf, unf
    );

    modport slave (
        input  stack_en, stack_rw, stack_rst, din,
        output dout, sp, full, empty, ovf, unf
    );
endinterface

// File: rtl/cpu_stack.sv
// Hardware LIFO for CPU push/pop; push is single-cycle, pop data is registered on dout one
// cycle after the request and a pop spans two cycles (EXEC1/EXEC2). No backpressure: full/empty only flag.
module cpu_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    cpu_stack_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        POP2 = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_q, sp_nxt;
    logic [WIDTH-1:0] dout_q, dout_nxt;
    logic             ovf_q, ovf_nxt;
    logic             unf_q, unf_nxt;
    logic             full, empty;
    logic             wr_en;

    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sp_q   <= sp_nxt;
            dout_q <= dout_nxt;
            ovf_q  <= ovf_nxt;
            unf_q  <= unf_nxt;
        end
    end

    // Array contents are never cleared; only sp defines what is live.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[sp_q[AW-1:0]] <= bus.din;
        end
    end

    always_comb begin
        state_nxt = state;
        sp_nxt    = sp_q;
        dout_nxt  = dout_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        wr_en     = 1'b0;

        if (bus.stack_rst) begin
            state_nxt = IDLE;
            sp_nxt    = '0;
            dout_nxt  = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else if (bus.stack_en && bus.stack_rw) begin
            state_nxt = IDLE;
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_en  = 1'b1;
                sp_nxt = sp_q + 1'b1;
            end
        end else if (bus.stack_en && state == IDLE) begin
            // EXEC1 of a pop: data is captured now and held through EXEC2.
            state_nxt = POP2;
            if (empty) begin
                dout_nxt = '0;
                unf_nxt  = 1'b1;
            end else begin
                dout_nxt = mem[AW'(sp_q - 1'b1)];
                sp_nxt   = sp_q - 1'b1;
            end
        end else begin
            state_nxt = IDLE;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.sp    = sp_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
